// File: rtl/alu_stage_skid_buffer_if.sv
// Handshake bundle for one side of the EX->MEM stage: valid/ready plus the
// lane vectors, destination register and the four control bits.
`timescale 1ns/1ps
interface alu_stage_skid_buffer_if #(
    parameter int N     = 18,
    parameter int LANES = 3,
    parameter int WA_W  = 4
);
    logic                        valid;
    logic                        ready;
    logic [0:LANES-1][N-1:0]     result;
    logic [0:LANES-1][N-1:0]     wdata;
    logic [WA_W-1:0]             wa3;
    logic                        pcsrc;
    logic                        regwrite;
    logic                        memtoreg;
    logic                        memwrite;

    modport master (
        output valid, result, wdata, wa3, pcsrc, regwrite, memtoreg, memwrite,
        input  ready
    );

    modport slave (
        input  valid, result, wdata, wa3, pcsrc, regwrite, memtoreg, memwrite,
        output ready
    );
endinterface

// File: rtl/alu_stage_skid_buffer.sv
// EX->MEM pipeline stage with a 2-entry skid buffer: a head register feeding
// the outputs and a skid register catching one transfer under back-pressure.
`timescale 1ns/1ps
module alu_stage_skid_buffer #(
    parameter int N     = 18,
    parameter int LANES = 3,
    parameter int WA_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    alu_stage_skid_buffer_if.slave  upstream,
    alu_stage_skid_buffer_if.master downstream,
    output logic [1:0]              occupancy
);

    typedef struct packed {
        logic [0:LANES-1][N-1:0] result;
        logic [0:LANES-1][N-1:0] wdata;
        logic [WA_W-1:0]         wa3;
        logic                    pcsrc;
        logic                    regwrite;
        logic                    memtoreg;
        logic                    memwrite;
    } entry_t;

    // Encoding chosen so bit 0 is the head-valid flag and bit 1 the skid-valid flag.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state;
    state_t state_next;
    entry_t head;
    entry_t skid;
    entry_t in_entry;
    logic   h_v;
    logic   s_v;
    logic   acc;
    logic   pop;
    logic   load_head_in;
    logic   load_head_skid;
    logic   load_skid;

    assign in_entry = '{
        result:   upstream.result,
        wdata:    upstream.wdata,
        wa3:      upstream.wa3,
        pcsrc:    upstream.pcsrc,
        regwrite: upstream.regwrite,
        memtoreg: upstream.memtoreg,
        memwrite: upstream.memwrite
    };

    assign h_v = (state == ONE) || (state == FULL);
    assign s_v = (state == FULL);
    assign acc = upstream.valid && !s_v;
    assign pop = h_v && downstream.ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        load_head_in = 1'b1;
                        state_next   = ONE;
                    end
                end
                ONE: begin
                    if (pop && acc) begin
                        load_head_in = 1'b1;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end else if (acc) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (pop) begin
                        load_head_skid = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // A flush loads nothing, so the data fields keep their last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_in) begin
                head <= in_entry;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= in_entry;
            end
        end
    end

    assign upstream.ready      = !s_v;
    assign downstream.valid    = h_v;
    assign downstream.result   = head.result;
    assign downstream.wdata    = head.wdata;
    assign downstream.wa3      = head.wa3;
    assign downstream.pcsrc    = head.pcsrc    && h_v;
    assign downstream.regwrite = head.regwrite && h_v;
    assign downstream.memtoreg = head.memtoreg && h_v;
    assign downstream.memwrite = head.memwrite && h_v;
    assign occupancy           = {s_v, h_v && !s_v};

endmodule

// File: tb/tb_alu_stage_skid_buffer.sv
// Bench for alu_stage_skid_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_alu_stage_skid_buffer;
    localparam int N     = 18;
    localparam int LANES = 3;
    localparam int WA_W  = 4;

    typedef struct packed {
        logic [0:LANES-1][N-1:0] result;
        logic [0:LANES-1][N-1:0] wdata;
        logic [WA_W-1:0]         wa3;
        logic                    pcsrc;
        logic                    regwrite;
        logic                    memtoreg;
        logic                    memwrite;
    } entry_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;

    alu_stage_skid_buffer_if #(.N(N), .LANES(LANES), .WA_W(WA_W)) up_if ();
    alu_stage_skid_buffer_if #(.N(N), .LANES(LANES), .WA_W(WA_W)) dn_if ();

    alu_stage_skid_buffer #(.N(N), .LANES(LANES), .WA_W(WA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .upstream   (up_if),
        .downstream (dn_if),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    entry_t drv;
    logic   iv;
    logic   ordy;
    assign up_if.valid    = iv;
    assign up_if.result   = drv.result;
    assign up_if.wdata    = drv.wdata;
    assign up_if.wa3      = drv.wa3;
    assign up_if.pcsrc    = drv.pcsrc;
    assign up_if.regwrite = drv.regwrite;
    assign up_if.memtoreg = drv.memtoreg;
    assign up_if.memwrite = drv.memwrite;
    assign dn_if.ready    = ordy;

    int     tests = 0;
    int     failed = 0;
    entry_t q[$];
    entry_t last_head;
    logic   check_en;
    int     accepts;
    int     flushed;
    int     dut_deliv = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic entry_t dut_out();
        entry_t e;
        e.result   = dn_if.result;
        e.wdata    = dn_if.wdata;
        e.wa3      = dn_if.wa3;
        e.pcsrc    = dn_if.pcsrc;
        e.regwrite = dn_if.regwrite;
        e.memtoreg = dn_if.memtoreg;
        e.memwrite = dn_if.memwrite;
        return e;
    endfunction

    // Advance one clock; the model is a FIFO of depth 2 whose head drives the outputs.
    task automatic cycle();
        bit     acc;
        bit     pop;
        entry_t e;
        acc = iv && (q.size() < 2);
        pop = (q.size() > 0) && ordy;
        e   = drv;
        @(posedge clk);
        #1;
        if (acc) accepts++;
        if (flush) begin
            flushed += q.size() - int'(pop) + int'(acc);
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (q.size() > 0) last_head = q[0];
    endtask

    always @(negedge clk) begin : compare
        entry_t exp_e;
        if (check_en) begin
            exp_e = last_head;
            if (q.size() == 0) begin
                exp_e.pcsrc    = 1'b0;
                exp_e.regwrite = 1'b0;
                exp_e.memtoreg = 1'b0;
                exp_e.memwrite = 1'b0;
            end
            check("out_valid", 128'(dn_if.valid), 128'(q.size() != 0));
            check("in_ready", 128'(up_if.ready), 128'(q.size() < 2));
            check("occupancy", 128'(occupancy), 128'(q.size()));
            check("head_entry", 128'(dut_out()), 128'(exp_e));
            if (dn_if.valid && ordy) dut_deliv++;
        end
    end

    initial begin
        int base_deliv;
        reset = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0; drv = '0;
        check_en = 1'b0; last_head = '0; accepts = 0; flushed = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_en = 1'b1;

        // Fill to FULL, then assert reset asynchronously mid-cycle.
        drv.result = {18'h3FFFF, 18'h1, 18'h2};
        drv.wdata = {18'h5, 18'h6, 18'h7};
        drv.wa3 = 4'd3; drv.regwrite = 1'b1; drv.memwrite = 1'b1;
        iv = 1'b1;
        cycle();
        cycle();
        iv = 1'b0;
        check("fill_occupancy", 128'(occupancy), 128'd2);
        #2;
        check_en = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_out_valid", 128'(dn_if.valid), 128'd0);
        check("rst_occupancy", 128'(occupancy), 128'd0);
        check("rst_in_ready", 128'(up_if.ready), 128'd1);
        check("rst_result", 128'(dn_if.result), 128'd0);
        check("rst_wdata", 128'(dn_if.wdata), 128'd0);
        check("rst_wa3", 128'(dn_if.wa3), 128'd0);
        check("rst_ctrl", 128'({dn_if.pcsrc, dn_if.regwrite, dn_if.memtoreg, dn_if.memwrite}), 128'd0);
        q.delete();
        last_head = '0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_en = 1'b1;

        // Streaming at full rate.
        drv = '0;
        ordy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            iv = 1'b1;
            drv.result[0] = N'(i);
            drv.wa3 = WA_W'(i);
            cycle();
            check("stream_result0", 128'(dn_if.result[0]), 128'(i));
            check("stream_valid", 128'(dn_if.valid), 128'd1);
            check("stream_occ", 128'(occupancy), 128'd1);
        end
        iv = 1'b0;
        cycle();

        // Back-pressure: A, B fill, C waits upstream.
        ordy = 1'b0;
        iv = 1'b1;
        drv.wa3 = 4'd5; cycle();
        drv.wa3 = 4'd6; cycle();
        check("bp_occ", 128'(occupancy), 128'd2);
        check("bp_in_ready", 128'(up_if.ready), 128'd0);
        drv.wa3 = 4'd7; cycle();
        check("bp_held_head", 128'(dn_if.wa3), 128'd5);
        ordy = 1'b1;
        cycle();
        check("bp_order_b", 128'(dn_if.wa3), 128'd6);
        cycle();
        check("bp_order_c", 128'(dn_if.wa3), 128'd7);
        iv = 1'b0;
        cycle();
        check("bp_drained", 128'(dn_if.valid), 128'd0);

        // Flush from FULL with a transfer offered in the same cycle.
        ordy = 1'b0;
        iv = 1'b1;
        drv.regwrite = 1'b1;
        drv.wa3 = 4'd8; cycle();
        drv.wa3 = 4'd9; cycle();
        check("fl_regwrite_pre", 128'(dn_if.regwrite), 128'd1);
        flush = 1'b1;
        drv.wa3 = 4'd10;
        cycle();
        flush = 1'b0;
        iv = 1'b0;
        check("fl_occ", 128'(occupancy), 128'd0);
        check("fl_regwrite", 128'(dn_if.regwrite), 128'd0);
        ordy = 1'b1;
        cycle();
        check("fl_no_d", 128'(dn_if.valid), 128'd0);

        // Control gating while empty, then a single memwrite transfer.
        drv = '0;
        drv.memwrite = 1'b1;
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("gate_empty_mw", 128'(dn_if.memwrite), 128'd0);
        end
        iv = 1'b1;
        cycle();
        iv = 1'b0;
        drv.memwrite = 1'b0;
        check("gate_mw_1", 128'(dn_if.memwrite), 128'd1);
        cycle();
        check("gate_mw_2", 128'(dn_if.memwrite), 128'd1);
        ordy = 1'b1;
        cycle();
        check("gate_mw_done", 128'(dn_if.memwrite), 128'd0);

        // Randomised traffic.
        accepts = 0;
        flushed = 0;
        base_deliv = dut_deliv;
        for (int c = 0; c < 10000; c++) begin
            iv = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 99) == 0);
            for (int l = 0; l < LANES; l++) begin
                drv.result[l] = N'($urandom);
                drv.wdata[l] = N'($urandom);
            end
            drv.wa3 = WA_W'($urandom);
            {drv.pcsrc, drv.regwrite, drv.memtoreg, drv.memwrite} = 4'($urandom);
            cycle();
        end
        iv = 1'b0; flush = 1'b0; ordy = 1'b1;
        repeat (4) cycle();
        @(negedge clk); #1;
        check("deliv_count", 128'(dut_deliv - base_deliv), 128'(accepts - flushed));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
